// File: rtl/fp16_dot_mac_pkg.sv
// Shared fp16 definitions for the dot-product engine: FSM states, binary16
// constants, field widths and the round-and-pack helper used by both cores.
// Build option: FP16_MAC_SAT_EN (saturating output, see fp16_dot_mac.sv).
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;

  localparam logic [15:0] POS_ZERO = 16'h0000;
  localparam logic [15:0] POS_INF  = 16'h7C00;
  localparam logic [15:0] NEG_INF  = 16'hFC00;
  localparam logic [15:0] POS_MAX  = 16'h7BFF;
  localparam logic [15:0] NEG_MAX  = 16'hFBFF;
  localparam logic [15:0] QNAN     = 16'h7E00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Round-to-nearest-even on a normalised 1.m significand, then pack.
  // Exponent overflow gives signed Inf, underflow flushes to signed zero.
  function automatic logic [15:0] rnd_pack(input logic s, input logic signed [7:0] e,
                                           input logic [MAN_W-1:0] m, input logic g,
                                           input logic st);
    logic              inc;
    logic [MAN_W+1:0]  sum;
    logic [MAN_W-1:0]  mo;
    logic signed [7:0] eo;
    inc = g & (st | m[0]);
    sum = {2'b01, m} + {{(MAN_W+1){1'b0}}, inc};
    if (sum[MAN_W+1]) begin
      mo = sum[MAN_W:1];
      eo = e + 8'sd1;
    end else begin
      mo = sum[MAN_W-1:0];
      eo = e;
    end
    if (eo >= 8'sd31)     return {s, POS_INF[14:0]};
    else if (eo <= 8'sd0) return {s, 15'd0};
    else                  return {s, eo[4:0], mo};
  endfunction

endpackage

// File: rtl/fp16_dot_mac_if.sv
// Operand/result stream bundle of the fp16 dot-product engine.
interface fp16_dot_mac_if #(parameter int LEN_W = 8);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      a;
  logic [15:0]      b;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      result;
  logic             busy;

  modport master (output start, len, in_valid, a, b, out_ready,
                  input  in_ready, out_valid, result, busy);
  modport slave  (input  start, len, in_valid, a, b, out_ready,
                  output in_ready, out_valid, result, busy);
endinterface

// File: rtl/fp16_dot_mac_ctrl.sv
// Dot-product sequencer: IDLE/RUN/WAIT/DONE FSM, pipeline wait counter,
// element counter and stream handshake outputs.
module fp16_dot_ctrl import fp16_pkg::*; #(
  parameter int LEN_W   = 8,
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             in_valid_i,
  input  logic             out_ready_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic             busy_o,
  output logic             in_fire_o,
  output logic             acc_clr_o,
  output logic             acc_we_o
);
  localparam int WAIT_CYC = MUL_LAT + ADD_LAT - 1;
  localparam int WCNT_W   = $clog2(WAIT_CYC + 1) + 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [WCNT_W-1:0] wcnt_q;
  logic              expire, last;

  assign expire = (state_q == S_WAIT) && (wcnt_q == '0);
  assign last   = ((cnt_q + LEN_W'(1)) == len_q);

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i)     state_d = (len_i == '0) ? S_DONE : S_RUN;
      S_RUN:   if (in_valid_i)  state_d = S_WAIT;
      S_WAIT:  if (expire)      state_d = last ? S_DONE : S_RUN;
      S_DONE:  if (out_ready_i) state_d = S_IDLE;
      default:                  state_d = S_IDLE;
    endcase
  end

  // Handshake and datapath strobes decoded from the current state
  always_comb begin
    in_ready_o  = (state_q == S_RUN);
    out_valid_o = (state_q == S_DONE);
    busy_o      = (state_q != S_IDLE);
    in_fire_o   = (state_q == S_RUN) && in_valid_i;
    acc_clr_o   = (state_q == S_IDLE) && start_i;
    acc_we_o    = expire;
  end

  // Length capture, wait countdown and element count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      len_q  <= '0;
      cnt_q  <= '0;
      wcnt_q <= '0;
    end else begin
      if (acc_clr_o) begin
        len_q <= len_i;
        cnt_q <= '0;
      end else if (expire) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
      if (in_fire_o)                               wcnt_q <= WCNT_W'(WAIT_CYC);
      else if ((state_q == S_WAIT) && !expire)     wcnt_q <= wcnt_q - WCNT_W'(1);
    end
  end
endmodule

// File: rtl/fp16_dot_mac_fpu.sv
// Pipelined binary16 multiplier and adder cores. Subnormal inputs are
// treated as zero and tiny results flush to zero; rounding is RNE.
module fp16multiplier import fp16_pkg::*; #(
  parameter int LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        vld_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic        vld_o,
  output logic [15:0] p_o
);
  logic [LAT-1:0][15:0] prod_p;
  logic [LAT-1:0]       vld_p;

  function automatic logic [15:0] fp_mul(input logic [15:0] x, input logic [15:0] y);
    logic              s, xn, yn, xi, yi, xz, yz;
    logic [21:0]       pr;
    logic signed [7:0] e;
    s  = x[15] ^ y[15];
    xn = (x[14:10] == 5'h1F) && (x[9:0] != '0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != '0);
    xi = (x[14:10] == 5'h1F) && (x[9:0] == '0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == '0);
    xz = (x[14:10] == 5'h00);
    yz = (y[14:10] == 5'h00);
    pr = 22'({1'b1, x[9:0]}) * 22'({1'b1, y[9:0]});
    e  = $signed({3'b000, x[14:10]}) + $signed({3'b000, y[14:10]}) - 8'sd15;
    if (xn || yn || (xi && yz) || (yi && xz)) return QNAN;
    else if (xi || yi)                        return {s, POS_INF[14:0]};
    else if (xz || yz)                        return {s, 15'd0};
    else if (pr[21])                          return rnd_pack(s, e + 8'sd1, pr[20:11], pr[10], |pr[9:0]);
    else                                      return rnd_pack(s, e, pr[19:10], pr[9], |pr[8:0]);
  endfunction

  // Data pipeline: product computed ahead of stage 0, then shifted
  always_ff @(posedge clk_i) begin
    prod_p[0] <= fp_mul(a_i, b_i);
    for (int i = 1; i < LAT; i++) prod_p[i] <= prod_p[i-1];
  end

  // Valid pipeline, cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) vld_p <= '0;
    else begin
      vld_p[0] <= vld_i;
      for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign p_o   = prod_p[LAT-1];
  assign vld_o = vld_p[LAT-1];
endmodule

module fpadder import fp16_pkg::*; #(
  parameter int LAT = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        vld_i,
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  output logic        vld_o,
  output logic [15:0] s_o
);
  logic [LAT-1:0][15:0] sum_p;
  logic [LAT-1:0]       vld_p;

  function automatic logic [15:0] fp_add(input logic [15:0] x, input logic [15:0] y);
    logic              xn, yn, xi, yi, xz, yz;
    logic [15:0]       big, sml;
    logic [4:0]        ed;
    logic [13:0]       bx, al, df;
    logic [24:0]       sh;
    logic [14:0]       sm;
    logic [12:0]       nm;
    logic [3:0]        lz;
    logic              found;
    logic signed [7:0] eb;
    xn = (x[14:10] == 5'h1F) && (x[9:0] != '0);
    yn = (y[14:10] == 5'h1F) && (y[9:0] != '0);
    xi = (x[14:10] == 5'h1F) && (x[9:0] == '0);
    yi = (y[14:10] == 5'h1F) && (y[9:0] == '0);
    xz = (x[14:10] == 5'h00);
    yz = (y[14:10] == 5'h00);
    if (xn || yn || (xi && yi && (x[15] != y[15]))) return QNAN;
    if (xi) return x;
    if (yi) return y;
    if (xz && yz) return {x[15] & y[15], 15'd0};
    if (xz) return y;
    if (yz) return x;
    // Align the smaller magnitude onto the larger, keeping guard/round/sticky
    if (x[14:0] >= y[14:0]) begin big = x; sml = y; end
    else                    begin big = y; sml = x; end
    eb = $signed({3'b000, big[14:10]});
    ed = big[14:10] - sml[14:10];
    bx = {1'b1, big[9:0], 3'b000};
    sh = {1'b1, sml[9:0], 14'd0} >> ed;
    if (ed > 5'd13) al = 14'd1;
    else            al = sh[24:11] | {13'd0, |sh[10:0]};
    if (big[15] == sml[15]) begin
      sm = {1'b0, bx} + {1'b0, al};
      if (sm[14]) return rnd_pack(big[15], eb + 8'sd1, sm[13:4], sm[3], |sm[2:0]);
      else        return rnd_pack(big[15], eb, sm[12:3], sm[2], |sm[1:0]);
    end
    df = bx - al;
    if (df == '0) return POS_ZERO;
    lz    = '0;
    found = 1'b0;
    for (int i = 13; i >= 0; i--) begin
      if (!found && df[i]) begin
        lz    = 4'(13 - i);
        found = 1'b1;
      end
    end
    nm = 13'(df << lz);
    return rnd_pack(big[15], eb - $signed({4'b0000, lz}), nm[12:3], nm[2], |nm[1:0]);
  endfunction

  // Data pipeline: sum computed ahead of stage 0, then shifted
  always_ff @(posedge clk_i) begin
    sum_p[0] <= fp_add(x_i, y_i);
    for (int i = 1; i < LAT; i++) sum_p[i] <= sum_p[i-1];
  end

  // Valid pipeline, cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) vld_p <= '0;
    else begin
      vld_p[0] <= vld_i;
      for (int i = 1; i < LAT; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  assign s_o   = sum_p[LAT-1];
  assign vld_o = vld_p[LAT-1];
endmodule

// File: rtl/fp16_dot_mac.sv
// fp16 dot-product engine top: sequencer, multiplier, adder, accumulator
// register and output stage. Build option FP16_MAC_SAT_EN clamps a +/-Inf
// result to +/-max finite at the output only; the accumulator is untouched.
module fp16_dot_mac import fp16_pkg::*; #(
  parameter int LEN_W   = 8,
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1
) (
  input  logic           CLK,
  input  logic           RESETn,
  fp16_dot_mac_if.slave  bus
);
  logic        in_fire, acc_clr, acc_we;
  logic        mul_vld, add_vld;
  logic [15:0] prod, sum;
  logic [15:0] acc_q, acc_d;

  fp16_dot_ctrl #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) u_ctrl (
    .clk_i       (CLK),
    .rst_ni      (RESETn),
    .start_i     (bus.start),
    .len_i       (bus.len),
    .in_valid_i  (bus.in_valid),
    .out_ready_i (bus.out_ready),
    .in_ready_o  (bus.in_ready),
    .out_valid_o (bus.out_valid),
    .busy_o      (bus.busy),
    .in_fire_o   (in_fire),
    .acc_clr_o   (acc_clr),
    .acc_we_o    (acc_we)
  );

  fp16multiplier #(.LAT(MUL_LAT)) u_mul (
    .clk_i (CLK), .rst_ni (RESETn), .vld_i (in_fire),
    .a_i (bus.a), .b_i (bus.b), .vld_o (mul_vld), .p_o (prod)
  );

  // The accumulator is stable for the whole WAIT phase, so it feeds the adder directly
  fpadder #(.LAT(ADD_LAT)) u_add (
    .clk_i (CLK), .rst_ni (RESETn), .vld_i (mul_vld),
    .x_i (prod), .y_i (acc_q), .vld_o (add_vld), .s_o (sum)
  );

  // Accumulator next value: cleared on start, loaded when the wait expires
  always_comb begin
    acc_d = acc_q;
    if (acc_clr)              acc_d = POS_ZERO;
    else if (acc_we && add_vld) acc_d = sum;
  end

  // Accumulator register
  always_ff @(posedge CLK) begin
    if (!RESETn) acc_q <= POS_ZERO;
    else         acc_q <= acc_d;
  end

`ifdef FP16_MAC_SAT_EN
  function automatic logic [15:0] sat_f(input logic [15:0] v);
    if (v == POS_INF)      return POS_MAX;
    else if (v == NEG_INF) return NEG_MAX;
    else                   return v;
  endfunction
  assign bus.result = sat_f(acc_q);
`else
  assign bus.result = acc_q;
`endif
endmodule

// File: tb/tb_fp16_dot_mac.sv
// Directed bench for fp16_dot_mac: vector table plus reset-mid-run sequence.
module tb_fp16_dot_mac;
  localparam int LEN_W   = 8;
  localparam int MUL_LAT = 1;
  localparam int ADD_LAT = 1;
  localparam int LAT     = MUL_LAT + ADD_LAT;
  localparam int NV      = 10;
`ifdef FP16_MAC_SAT_EN
  localparam logic [15:0] OVF_RES = 16'h7BFF;
`else
  localparam logic [15:0] OVF_RES = 16'h7C00;
`endif

  logic CLK = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  fp16_dot_mac_if #(.LEN_W(LEN_W)) bus ();
  fp16_dot_mac #(.LEN_W(LEN_W), .MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) dut (
    .CLK (CLK), .RESETn (RESETn), .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int               len;
    logic [2:0][15:0] a;
    logic [2:0][15:0] b;
    logic [15:0]      res;
    int               gap;
    int               hold;
  } vec_t;
  vec_t vt[NV];
  vec_t rj;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input int len, input logic [15:0] a0, input logic [15:0] b0,
                              input logic [15:0] a1, input logic [15:0] b1,
                              input logic [15:0] a2, input logic [15:0] b2,
                              input logic [15:0] res, input int gap, input int hold);
    vec_t v;
    v.len = len; v.res = res; v.gap = gap; v.hold = hold;
    v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1; v.a[2] = a2; v.b[2] = b2;
    return v;
  endfunction

  task automatic run_job(input vec_t v, input string tag);
    int n;
    bus.len   = LEN_W'(v.len);
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    if (v.len == 0) chk($sformatf("%s len0 in_ready", tag), 32'(bus.in_ready), 0);
    for (int k = 0; k < v.len; k++) begin
      chk($sformatf("%s in_ready e%0d", tag, k), 32'(bus.in_ready), 1);
      for (int g = 0; g < v.gap; g++) begin
        bus.start = 1'b1;
        bus.len   = '0;
        @(negedge CLK);
      end
      bus.start    = 1'b0;
      bus.in_valid = 1'b1;
      bus.a        = v.a[k];
      bus.b        = v.b[k];
      @(negedge CLK);
      bus.a = 16'($urandom);
      bus.b = 16'($urandom);
      for (n = 1; n <= LAT + 4; n++) begin
        if ((k == v.len - 1) ? bus.out_valid : bus.in_ready) break;
        bus.in_valid = 1'b1;
        @(negedge CLK);
      end
      bus.in_valid = 1'b0;
      chk($sformatf("%s latency e%0d", tag, k), 32'(n), 32'(LAT + 1));
    end
    chk($sformatf("%s out_valid", tag), 32'(bus.out_valid), 1);
    chk($sformatf("%s result", tag), 32'(bus.result), 32'(v.res));
    chk($sformatf("%s in_ready done", tag), 32'(bus.in_ready), 0);
    for (int h = 0; h < v.hold; h++) begin
      bus.start = 1'b1;
      bus.len   = 8'd1;
      @(negedge CLK);
      chk($sformatf("%s held result h%0d", tag, h), 32'(bus.result), 32'(v.res));
      chk($sformatf("%s held out_valid h%0d", tag, h), 32'(bus.out_valid), 1);
    end
    bus.start     = 1'b1;
    bus.len       = 8'd1;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    chk($sformatf("%s out_valid after hs", tag), 32'(bus.out_valid), 0);
    chk($sformatf("%s busy after hs", tag), 32'(bus.busy), 0);
    @(negedge CLK);
    chk($sformatf("%s busy idle gap", tag), 32'(bus.busy), 0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    vt[0] = mk(2, 16'h3C00, 16'h4000, 16'h4000, 16'h4200, 16'h0, 16'h0, 16'h4800, 0, 0);
    vt[1] = mk(2, 16'h3C00, 16'h4000, 16'h4000, 16'h4200, 16'h0, 16'h0, 16'h4800, 3, 5);
    vt[2] = mk(2, 16'hBC00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h0, 16'h0, 16'h0000, 0, 0);
    vt[3] = mk(1, 16'h7BFF, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, OVF_RES, 0, 1);
    vt[4] = mk(3, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00, 16'h4200, 1, 0);
    vt[5] = mk(1, 16'h3E00, 16'h3E00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4080, 0, 0);
    vt[6] = mk(2, 16'h3800, 16'h3800, 16'h3E00, 16'h3E00, 16'h0, 16'h0, 16'h4100, 0, 2);
    vt[7] = mk(1, 16'h7E00, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7E00, 0, 0);
    vt[8] = mk(1, 16'h7C00, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7E00, 0, 0);
    vt[9] = mk(0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0000, 0, 2);
    rj    = mk(1, 16'h3C00, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h3C00, 0, 0);

    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    RESETn = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset in_ready", 32'(bus.in_ready), 0);
    chk("reset out_valid", 32'(bus.out_valid), 0);
    chk("reset busy", 32'(bus.busy), 0);
    chk("reset result", 32'(bus.result), 0);
    RESETn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < NV; i++) run_job(vt[i], $sformatf("v%0d", i));

    // Reset during WAIT of element 2 of a 4-element job
    bus.len   = 8'd4;
    bus.start = 1'b1;
    @(negedge CLK);
    bus.start = 1'b0;
    for (int e = 0; e < 2; e++) begin
      for (n = 0; n < LAT + 4; n++) begin
        if (bus.in_ready) break;
        @(negedge CLK);
      end
      chk($sformatf("rstseq in_ready e%0d", e), 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.a = 16'h3C00;
      bus.b = 16'h3C00;
      @(negedge CLK);
      bus.in_valid = 1'b0;
    end
    chk("rstseq busy before reset", 32'(bus.busy), 1);
    RESETn = 1'b0;
    @(negedge CLK);
    chk("rstseq in_ready", 32'(bus.in_ready), 0);
    chk("rstseq out_valid", 32'(bus.out_valid), 0);
    chk("rstseq busy", 32'(bus.busy), 0);
    chk("rstseq result", 32'(bus.result), 0);
    RESETn = 1'b1;
    @(negedge CLK);
    run_job(rj, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
